ehl_ecc_scrub: RTL and testbench



---
 rtl/ehl_ecc_scrub.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_ehl_ecc_scrub.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ehl_ecc_scrub.sv
// ehl_ecc_scrub: SECDED memory controller with a background scrubber.
// The host port gets encoded writes and corrected reads. A timer-driven
// scrubber walks the RAM, writes corrected codewords back on single errors
// and counts single/double errors.
// Optional feature macro: EHL_ECC_SCRUB_LOG_EN (adds a first-double-error
// address log, ports derr_log_vld / derr_log_addr).

// ehl_ecc: Hamming encoder/decoder with an optional overall parity bit.
// Data bit j sits at the j-th non-power-of-two Hamming position (3,5,6,7,9...).
// cbout = {overall parity, check bits}.
module ehl_ecc #(
    parameter int WIDTH  = 8,
    parameter int SECDED = 1,
    localparam int CWIDTH = 1 + $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]  din,
    input  logic [CWIDTH:0]   cbin,
    output logic [WIDTH-1:0]  dout,
    output logic [CWIDTH:0]   cbout,
    output logic              single_err,
    output logic              double_err
);
    // Hamming position of each data bit, packed CWIDTH bits per entry
    function automatic logic [WIDTH*CWIDTH-1:0] pos_table();
        logic [WIDTH*CWIDTH-1:0] t;
        int k;
        t = '0;
        k = 0;
        for (int p = 3; p < (1 << CWIDTH); p++) begin
            if (((p & (p - 1)) != 0) && (k < WIDTH)) begin
                t[k*CWIDTH +: CWIDTH] = CWIDTH'(p);
                k++;
            end
        end
        return t;
    endfunction

    localparam logic [WIDTH*CWIDTH-1:0] POS = pos_table();

    logic [CWIDTH-1:0] chk;
    logic [CWIDTH-1:0] syn;
    logic              par;

    // check bits: XOR of the positions of all set data bits
    always_comb begin
        chk = '0;
        for (int j = 0; j < WIDTH; j++) begin
            if (din[j]) chk = chk ^ POS[j*CWIDTH +: CWIDTH];
        end
    end

    assign cbout = {^{din, chk}, chk};
    assign syn   = chk ^ cbin[CWIDTH-1:0];
    assign par   = ^{din, cbin};

    // classify the error and flip the data bit the syndrome points at
    always_comb begin
        if (SECDED != 0) begin
            single_err = par;
            double_err = !par && (syn != '0);
        end else begin
            single_err = (syn != '0);
            double_err = 1'b0;
        end
        dout = din;
        for (int j = 0; j < WIDTH; j++) begin
            if (single_err && (syn == POS[j*CWIDTH +: CWIDTH])) dout[j] = ~din[j];
        end
    end
endmodule

module ehl_ecc_scrub #(
    parameter int WIDTH  = 8,
    parameter int AWIDTH = 6,
    parameter int CNTW   = 8,
    localparam int CWIDTH = 1 + $clog2(WIDTH),
    localparam int CW     = WIDTH + CWIDTH + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [AWIDTH-1:0] host_addr,
    input  logic [WIDTH-1:0]  host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [WIDTH-1:0]  host_rdata,
    output logic              host_serr,
    output logic              host_derr,
    input  logic              scrub_en,
    input  logic [15:0]       scrub_period,
    input  logic              cnt_clr,
    output logic [CNTW-1:0]   serr_cnt,
    output logic [CNTW-1:0]   derr_cnt,
    output logic              scrub_done,
`ifdef EHL_ECC_SCRUB_LOG_EN
    output logic              derr_log_vld,
    output logic [AWIDTH-1:0] derr_log_addr,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [CW-1:0]     mem_wdata,
    input  logic [CW-1:0]     mem_rdata
);
    typedef enum logic [1:0] {IDLE, HRD, SRD, SWB} state_t;

    state_t            state, state_nxt;
    logic [AWIDTH-1:0] scrub_addr;
    logic [AWIDTH-1:0] swb_addr;
    logic [CW-1:0]     swb_cw;
    logic [15:0]       timer;
    logic              scrub_pend;
    logic [3:0]        starve_cnt;
    logic              scrub_issue;

    // ECC datapaths: host write encode, shared read decode, scrub re-encode
    logic [CWIDTH:0]   wenc_cb, renc_cb, dec_cb;
    logic [WIDTH-1:0]  wenc_d, renc_d, dec_data;
    logic              wenc_s, wenc_x, renc_s, renc_x, dec_serr, dec_derr;
    logic [2*WIDTH+CWIDTH+4:0] ecc_unused;

    ehl_ecc #(.WIDTH(WIDTH), .SECDED(1)) u_wenc (
        .din(host_wdata), .cbin('0), .dout(wenc_d), .cbout(wenc_cb),
        .single_err(wenc_s), .double_err(wenc_x));

    ehl_ecc #(.WIDTH(WIDTH), .SECDED(1)) u_dec (
        .din(mem_rdata[WIDTH-1:0]), .cbin(mem_rdata[CW-1:WIDTH]), .dout(dec_data),
        .cbout(dec_cb), .single_err(dec_serr), .double_err(dec_derr));

    ehl_ecc #(.WIDTH(WIDTH), .SECDED(1)) u_renc (
        .din(dec_data), .cbin('0), .dout(renc_d), .cbout(renc_cb),
        .single_err(renc_s), .double_err(renc_x));

    assign ecc_unused = {wenc_d, wenc_s, wenc_x, renc_d, renc_s, renc_x, dec_cb};

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // arbitration, RAM strobes and next state; everything quiet in reset
    always_comb begin
        state_nxt   = state;
        host_gnt    = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        scrub_issue = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (scrub_pend && (!host_req || starve_cnt == 4'hF)) begin
                        scrub_issue = 1'b1;
                        mem_en      = 1'b1;
                        mem_addr    = scrub_addr;
                        state_nxt   = SRD;
                    end else if (host_req) begin
                        host_gnt = 1'b1;
                        mem_en   = 1'b1;
                        mem_addr = host_addr;
                        if (host_we) begin
                            mem_we    = 1'b1;
                            mem_wdata = {wenc_cb, host_wdata};
                        end else begin
                            state_nxt = HRD;
                        end
                    end
                end
                HRD: state_nxt = IDLE;
                SRD: state_nxt = dec_serr ? SWB : IDLE;
                SWB: begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = swb_addr;
                    mem_wdata = swb_cw;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // wrap marker shown during the check of the last address
    assign scrub_done = !reset && (state == SRD) && (scrub_addr == '1);

    // scrub timer, pending flag, starvation guard, walk address, writeback regs
    always_ff @(posedge clk) begin
        if (reset) begin
            scrub_addr <= '0;
            swb_addr   <= '0;
            swb_cw     <= '0;
            timer      <= '0;
            scrub_pend <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (state == SRD) begin
                scrub_addr <= scrub_addr + 1'b1;
                swb_addr   <= scrub_addr;
                swb_cw     <= {renc_cb, dec_data};
            end
            if (!scrub_en) begin
                timer      <= '0;
                scrub_pend <= 1'b0;
                starve_cnt <= '0;
            end else begin
                if (scrub_issue)
                    starve_cnt <= '0;
                else if (state == IDLE && scrub_pend && host_req)
                    starve_cnt <= starve_cnt + 1'b1;
                if (state == SRD) begin
                    scrub_pend <= 1'b0;
                end else if (!scrub_pend) begin
                    if (timer == scrub_period) begin
                        scrub_pend <= 1'b1;
                        timer      <= '0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
            end
        end
    end

    // host read return: corrected data and flags one cycle after HRD
    always_ff @(posedge clk) begin
        if (reset) begin
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
            host_serr   <= 1'b0;
            host_derr   <= 1'b0;
        end else begin
            host_rvalid <= (state == HRD);
            host_serr   <= (state == HRD) && dec_serr;
            host_derr   <= (state == HRD) && dec_derr;
            if (state == HRD) host_rdata <= dec_data;
        end
    end

    logic serr_inc, derr_inc;
    assign serr_inc = (host_rvalid && host_serr) || (state == SRD && dec_serr);
    assign derr_inc = (host_rvalid && host_derr) || (state == SRD && dec_derr);

    // saturating error counters; clear beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            serr_cnt <= '0;
            derr_cnt <= '0;
        end else begin
            if (serr_inc && serr_cnt != '1) serr_cnt <= serr_cnt + 1'b1;
            if (derr_inc && derr_cnt != '1) derr_cnt <= derr_cnt + 1'b1;
        end
    end

`ifdef EHL_ECC_SCRUB_LOG_EN
    logic [AWIDTH-1:0] hrd_addr;

    // remember the host read address so a host double error can be logged
    always_ff @(posedge clk) begin
        if (reset)                    hrd_addr <= '0;
        else if (host_gnt && !host_we) hrd_addr <= host_addr;
    end

    // capture only the first double error until reset or cnt_clr
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            derr_log_vld  <= 1'b0;
            derr_log_addr <= '0;
        end else if (!derr_log_vld) begin
            if (state == SRD && dec_derr) begin
                derr_log_vld  <= 1'b1;
                derr_log_addr <= scrub_addr;
            end else if (host_rvalid && host_derr) begin
                derr_log_vld  <= 1'b1;
                derr_log_addr <= hrd_addr;
            end
        end
    end
`endif
endmodule

// File: tb/tb_ehl_ecc_scrub.sv
// Directed bench for ehl_ecc_scrub. Codewords are hand-computed:
// codeword(0xA5)=13'h03A5, codeword(0x3C)=13'h123C, codeword(0x11)=13'h0A11,
// codeword(0x00)=13'h0000. Instance u1 uses defaults, u2 uses AWIDTH=2, CNTW=2.
module tb_ehl_ecc_scrub;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // instance 1 (default parameters)
    logic        host_req, host_we, host_gnt, host_rvalid, host_serr, host_derr;
    logic [5:0]  host_addr;
    logic [7:0]  host_wdata, host_rdata;
    logic        scrub_en, cnt_clr, scrub_done, mem_en, mem_we;
    logic [15:0] scrub_period;
    logic [7:0]  serr_cnt, derr_cnt;
    logic [5:0]  mem_addr;
    logic [12:0] mem_wdata, mem_rdata;
    logic        log_vld;
    logic [5:0]  log_addr;

    // instance 2 (AWIDTH=2, CNTW=2), scrub only
    logic        gnt2, rvalid2, serr2, derr2, done2, mem_en2, mem_we2;
    logic [7:0]  rdata2;
    logic        scrub_en2;
    logic [1:0]  serr_cnt2, derr_cnt2, mem_addr2;
    logic [12:0] mem_wdata2, mem_rdata2;
    logic        log_vld2;
    logic [1:0]  log_addr2;

    // preload port into the bench RAM
    logic        pl_en;
    logic [5:0]  pl_addr;
    logic [12:0] pl_data;
    logic [12:0] ram1 [64];

    ehl_ecc_scrub u1 (
        .clk(clk), .reset(reset), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_serr(host_serr),
        .host_derr(host_derr), .scrub_en(scrub_en), .scrub_period(scrub_period),
        .cnt_clr(cnt_clr), .serr_cnt(serr_cnt), .derr_cnt(derr_cnt),
        .scrub_done(scrub_done),
`ifdef EHL_ECC_SCRUB_LOG_EN
        .derr_log_vld(log_vld), .derr_log_addr(log_addr),
`endif
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

    ehl_ecc_scrub #(.AWIDTH(2), .CNTW(2)) u2 (
        .clk(clk), .reset(reset), .host_req(1'b0), .host_we(1'b0),
        .host_addr(2'd0), .host_wdata(8'd0), .host_gnt(gnt2),
        .host_rvalid(rvalid2), .host_rdata(rdata2), .host_serr(serr2),
        .host_derr(derr2), .scrub_en(scrub_en2), .scrub_period(16'd0),
        .cnt_clr(1'b0), .serr_cnt(serr_cnt2), .derr_cnt(derr_cnt2),
        .scrub_done(done2),
`ifdef EHL_ECC_SCRUB_LOG_EN
        .derr_log_vld(log_vld2), .derr_log_addr(log_addr2),
`endif
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2));

    // RAM for u1: synchronous single port, read data one cycle after strobe
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) ram1[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (pl_en) ram1[pl_addr] <= pl_data;
            if (mem_en) begin
                if (mem_we) ram1[mem_addr] <= mem_wdata;
                else        mem_rdata <= ram1[mem_addr];
            end
        end
    end

    // RAM for u2: every word reads back as codeword(0) with data bit 0 flipped
    always @(posedge clk) begin
        if (reset)                    mem_rdata2 <= '0;
        else if (mem_en2 && !mem_we2) mem_rdata2 <= 13'h0001;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n, found, wrs, grants, nrd, nwr, ndone, cyc, lastrd, wbor;
        logic [1:0] lastaddr;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        scrub_en = 0; scrub_period = '0; cnt_clr = 0; scrub_en2 = 0;
        pl_en = 0; pl_addr = '0; pl_data = '0;
        repeat (3) step();
        // reset state
        check("rst_gnt", 32'(host_gnt), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_rvalid", 32'(host_rvalid), 0);
        check("rst_rdata", 32'(host_rdata), 0);
        check("rst_serr_cnt", 32'(serr_cnt), 0);
        check("rst_derr_cnt", 32'(derr_cnt), 0);
        check("rst_done", 32'(scrub_done), 0);
        reset = 0;
        step();

        // clean write then read of 0xA5 at address 3
        host_req = 1; host_we = 1; host_addr = 6'd3; host_wdata = 8'hA5; #1;
        check("wr_gnt", 32'(host_gnt), 1);
        check("wr_we", 32'(mem_we), 1);
        check("wr_addr", 32'(mem_addr), 3);
        check("wr_cw", 32'(mem_wdata), 32'h03A5);
        step();
        host_we = 0; #1;
        check("rd_gnt", 32'(host_gnt), 1);
        check("rd_we", 32'(mem_we), 0);
        step();
        check("rd_t1_nognt", 32'(host_gnt), 0);
        host_req = 0;
        step();
        check("rd_rvalid", 32'(host_rvalid), 1);
        check("rd_rdata", 32'(host_rdata), 32'hA5);
        check("rd_serr", 32'(host_serr), 0);
        check("rd_derr", 32'(host_derr), 0);
        step();
        check("rd_rvalid_off", 32'(host_rvalid), 0);
        check("rd_cnts", 32'({serr_cnt, derr_cnt}), 0);
        check("rd_ram3", 32'(ram1[3]), 32'h03A5);

        // host single error: codeword(0x3C) with data bit 2 flipped at address 5
        pl_en = 1; pl_addr = 6'd5; pl_data = 13'h1238;
        step();
        pl_en = 0; host_req = 1; host_we = 0; host_addr = 6'd5; #1;
        check("hs_gnt", 32'(host_gnt), 1);
        check("hs_we0", 32'(mem_we), 0);
        step();
        host_req = 0; #1;
        check("hs_hrd_idle", 32'(mem_en), 0);
        step();
        check("hs_rdata", 32'(host_rdata), 32'h3C);
        check("hs_serr", 32'({host_rvalid, host_serr, host_derr}), 32'b110);
        step();
        check("hs_serr_cnt", 32'(serr_cnt), 1);
        check("hs_ram5", 32'(ram1[5]), 32'h1238);

        // scrub correction: codeword(0x11) with check bit 1 flipped at address 0
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        check("clr_serr_cnt", 32'(serr_cnt), 0);
        pl_en = 1; pl_addr = 6'd0; pl_data = 13'h0811;
        step();
        pl_en = 0; scrub_period = 16'd4; scrub_en = 1; #1;
        n = 0; found = 0;
        for (int i = 0; i < 50; i++) begin
            if (mem_en && !mem_we) begin found = 1; break; end
            step();
            n++;
        end
        check("sc_found", 32'(found), 1);
        check("sc_latency", 32'(n), 5);
        check("sc_raddr", 32'(mem_addr), 0);
        step();
        check("sc_srd_quiet", 32'(mem_en), 0);
        step();
        check("sc_swb_we", 32'({mem_en, mem_we}), 32'b11);
        check("sc_swb_addr", 32'(mem_addr), 0);
        check("sc_swb_cw", 32'(mem_wdata), 32'h0A11);
        scrub_en = 0;
        step();
        check("sc_serr_cnt", 32'(serr_cnt), 1);
        check("sc_ram0", 32'(ram1[0]), 32'h0A11);

        // double error: codeword(0x11) with data bits 0 and 7 flipped at address 2
        pl_en = 1; pl_addr = 6'd2; pl_data = 13'h0A90;
        step();
        pl_en = 0; scrub_period = 16'd0; scrub_en = 1; #1;
        found = 0; nrd = 0; wrs = 0;
        for (int i = 0; i < 50; i++) begin
            if (mem_we) wrs++;
            if (mem_en && !mem_we) begin
                nrd++;
                if (nrd == 1) check("db_first_addr", 32'(mem_addr), 1);
                if (mem_addr == 6'd2) begin found = 1; break; end
            end
            step();
        end
        check("db_found", 32'(found), 1);
        scrub_en = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (mem_we) wrs++;
        end
        check("db_no_wb", 32'(wrs), 0);
        check("db_derr_cnt", 32'(derr_cnt), 1);
        check("db_serr_cnt", 32'(serr_cnt), 1);
        check("db_ram2", 32'(ram1[2]), 32'h0A90);
`ifdef EHL_ECC_SCRUB_LOG_EN
        check("db_log_vld", 32'(log_vld), 1);
        check("db_log_addr", 32'(log_addr), 2);
`endif

        // starvation: continuous host writes, scrub wins on the 16th blocked cycle
        step();
        host_req = 1; host_we = 1; host_addr = 6'd40; host_wdata = 8'h00;
        scrub_period = 16'd4; scrub_en = 1; #1;
        grants = 0; found = 0;
        for (int i = 0; i < 40; i++) begin
            if (host_gnt) grants++;
            else begin found = 1; break; end
            step();
        end
        check("st_found", 32'(found), 1);
        check("st_grants", 32'(grants), 20);
        check("st_scrub_rd", 32'({mem_en, mem_we}), 32'b10);
        check("st_scrub_addr", 32'(mem_addr), 3);
        host_req = 0; scrub_en = 0;
        repeat (3) step();

        // cnt_clr in the same cycle as a host single-error increment
        host_req = 1; host_we = 0; host_addr = 6'd5;
        step();
        host_req = 0;
        step();
        cnt_clr = 1; #1;
        check("cc_rvalid_serr", 32'({host_rvalid, host_serr}), 32'b11);
        step();
        cnt_clr = 0;
        check("cc_serr_cnt", 32'(serr_cnt), 0);
        check("cc_derr_cnt", 32'(derr_cnt), 0);
`ifdef EHL_ECC_SCRUB_LOG_EN
        check("cc_log_vld", 32'(log_vld), 0);
`endif

        // u2: wrap after 4 scrubs, counter saturation with 5 single errors
        scrub_en2 = 1; #1;
        nrd = 0; nwr = 0; ndone = 0; cyc = 0; lastrd = -10; lastaddr = '0; wbor = 0;
        for (int i = 0; i < 80; i++) begin
            if (mem_en2 && !mem_we2) begin
                nrd++; lastaddr = mem_addr2; lastrd = cyc;
            end
            if (done2) begin
                ndone++;
                if (ndone == 1) begin
                    check("wr_done_nrd", 32'(nrd), 4);
                    check("wr_done_addr", 32'(lastaddr), 3);
                    check("wr_done_srd", 32'(cyc - lastrd), 1);
                end
            end
            if (mem_we2) begin
                nwr++;
                wbor = wbor | 32'(mem_wdata2);
                if (nwr == 2) check("sat_cnt_2", 32'(serr_cnt2), 2);
                if (nwr == 5) begin
                    check("sat_cnt_5", 32'(serr_cnt2), 3);
                    break;
                end
            end
            step();
            cyc++;
        end
        scrub_en2 = 0;
        check("wr_nwr", 32'(nwr), 5);
        check("wr_ndone", 32'(ndone), 1);
        check("wr_wb_data", 32'(wbor), 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
